// File: rtl/tdm_demux1to8_jdl25175_pkg.sv
// Shared definitions for the TDM 1-to-8 serial demultiplexer.
// Optional feature: define TDM_PARITY_EN to add an even-parity slot after
// the N data slots (frame becomes N+1 slots, parity_err becomes live).
package tdm_demux1to8_jdl25175_pkg;

    // Default slot-index width; N = 2**SEL_W slots per frame.
    localparam int DEFAULT_SEL_W = 3;

    // Receiver FSM encodings.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PARITY  = 2'd2
    } state_t;

endpackage

// File: rtl/slot_counter_jdl25175.sv
// Slot index counter: loads 1 when a frame starts (slot 0 is taken in the
// same cycle as sync), clears to 0 at frame end, steps per data slot.
// tc flags the last data slot (N-1).
module slot_counter_jdl25175
    import tdm_demux1to8_jdl25175_pkg::*;
#(
    parameter int SEL_W = DEFAULT_SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             clear,
    input  logic             step,
    output logic [SEL_W-1:0] count,
    output logic             tc
);

    // Slot index register; start wins over clear, clear over step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            if (start) begin
                count <= SEL_W'(1);
            end else if (clear) begin
                count <= '0;
            end else if (step) begin
                count <= count + SEL_W'(1);
            end
        end
    end

    assign tc = (count == {SEL_W{1'b1}});

endmodule

// File: rtl/tdm_demux1to8_jdl25175.sv
// Receive side of a TDM serial line: de-serializes one bit per enabled
// clock into an N-bit word, slot k -> dout[k], frame start marked by sync.
// Optional feature: define TDM_PARITY_EN for a trailing even-parity slot.
module tdm_demux1to8_jdl25175
    import tdm_demux1to8_jdl25175_pkg::*;
#(
    parameter int SEL_W = DEFAULT_SEL_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  sync,
    input  logic                  din,
    output logic [(2**SEL_W)-1:0] dout,
    output logic                  valid,
    output logic [SEL_W-1:0]      slot,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  parity_err
);

    localparam int N = 2**SEL_W;

    state_t         state, state_n;
    logic [N-1:0]   acc, acc_n;
    logic [N-1:0]   dout_n;
    logic           valid_n;
    logic           frame_err_n;
    logic           cnt_start;
    logic           cnt_clear;
    logic           cnt_step;
    logic           last_slot;
`ifdef TDM_PARITY_EN
    logic           parity_err_n;
`endif

    slot_counter_jdl25175 #(.SEL_W(SEL_W)) u_slot_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .start (cnt_start),
        .clear (cnt_clear),
        .step  (cnt_step),
        .count (slot),
        .tc    (last_slot)
    );

    // Next-state, accumulator and output-pulse decode.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned; that is what keeps this block latch-free.
        state_n     = state;
        acc_n       = acc;
        dout_n      = dout;
        valid_n     = 1'b0;
        frame_err_n = 1'b0;
        cnt_start   = 1'b0;
        cnt_clear   = 1'b0;
        cnt_step    = 1'b0;
`ifdef TDM_PARITY_EN
        parity_err_n = 1'b0;
`endif
        if (en) begin
            unique case (state)
                IDLE: begin
                    if (sync) begin
                        acc_n     = '0;
                        acc_n[0]  = din;
                        cnt_start = 1'b1;
                        state_n   = COLLECT;
                    end
                end
                COLLECT: begin
                    if (sync) begin
                        // Early sync: drop the partial word, din is new slot 0.
                        frame_err_n = 1'b1;
                        acc_n       = '0;
                        acc_n[0]    = din;
                        cnt_start   = 1'b1;
                    end else begin
                        acc_n[slot] = din;
                        if (last_slot) begin
                            cnt_clear = 1'b1;
`ifdef TDM_PARITY_EN
                            state_n   = PARITY;
`else
                            dout_n    = acc_n;
                            valid_n   = 1'b1;
                            state_n   = IDLE;
`endif
                        end else begin
                            cnt_step = 1'b1;
                        end
                    end
                end
`ifdef TDM_PARITY_EN
                PARITY: begin
                    if (sync) begin
                        frame_err_n = 1'b1;
                        acc_n       = '0;
                        acc_n[0]    = din;
                        cnt_start   = 1'b1;
                        state_n     = COLLECT;
                    end else begin
                        dout_n       = acc;
                        valid_n      = 1'b1;
                        parity_err_n = ^{acc, din};
                        state_n      = IDLE;
                    end
                end
`endif
                default: state_n = IDLE;
            endcase
        end
    end

    // State, accumulator and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            dout      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values computed above, independent of order.
            state     <= state_n;
            acc       <= acc_n;
            dout      <= dout_n;
            valid     <= valid_n;
            frame_err <= frame_err_n;
            busy      <= (state_n != IDLE);
        end
    end

`ifdef TDM_PARITY_EN
    // Parity error pulse, aligned with valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= parity_err_n;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
